// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module   : rv_mem_pkg
// Purpose  : Shared types and constants for the unified-memory arbiter of the
//            multicycle RISC-V core.
// Contents : arb_state_t - arbiter sequencing states
//            gnt_t       - requester identity (core / DMA)
//            LAT_W       - width of the memory-latency down-counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DMA  = 1'b1
    } gnt_t;

    // Wide enough for the largest supported memory latency (15).
    localparam int LAT_W = 4;

endpackage

`default_nettype wire

// File: rtl/rv_arb_rr2.sv
// ============================================================================
// Module   : rv_arb_rr2
// Purpose  : Combinational two-way picker. With a single requester active it
//            wins; with both active, round-robin (fair=1) picks the one not
//            granted last, fixed priority (fair=0) always picks the core.
// Ports    : req[1:0]   in  request vector, bit 0 = core, bit 1 = DMA
//            last_grant in  requester granted most recently (gnt_t encoding)
//            fair       in  1 = round-robin, 0 = core-priority
//            winner     out chosen requester (gnt_t encoding); only
//                           meaningful when req != 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_arb_rr2
    import rv_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fair,
    output logic       winner
);

    always_comb begin
        winner = GNT_CORE;
        case (req)
            2'b01:   winner = GNT_CORE;
            2'b10:   winner = GNT_DMA;
            2'b11:   winner = fair ? ~last_grant : GNT_CORE;
            default: winner = GNT_CORE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv_mem_arb.sv
// ============================================================================
// Module   : rv_mem_arb
// Purpose  : Shares the single-port unified memory between the core and a
//            DMA/debug port. Each requester uses a req/ack handshake; every
//            access is a one-cycle memory strobe followed, for reads, by a
//            fixed MEM_LAT wait before the data is captured.
// Ports    : clk, rst_n                     clock, async active-low reset
//            core_req/we/addr/wdata         core request (held until ack)
//            core_rdata, core_ack           core read data / completion pulse
//            dma_req/we/addr/wdata          DMA request (held until ack)
//            dma_rdata, dma_ack             DMA read data / completion pulse
//            mem_en/we/addr/wdata           memory macro command
//            mem_rdata                      memory macro read data
//            busy                           arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mem_arb
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter bit FAIR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [1:0]       c_ST_IDLE   = IDLE;
    localparam logic [1:0]       c_ST_ACCESS = ACCESS;
    localparam logic [1:0]       c_ST_WAIT   = WAIT;
    localparam logic [1:0]       c_ST_DONE   = DONE;
    localparam logic [LAT_W-1:0] c_LAT       = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] c_CNT_ONE   = LAT_W'(1);

    logic [1:0]        r_state;
    logic              r_gnt;
    logic              r_last_grant;
    logic [LAT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic [1:0]        w_req;
    logic              w_winner;
    logic              w_access;
    logic              w_done;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_req = {dma_req, core_req};

    rv_arb_rr2 u_pick (
        .req        (w_req),
        .last_grant (r_last_grant),
        .fair       (FAIR),
        .winner     (w_winner)
    );

    // Request fields come straight from the granted requester; they are
    // required to stay stable until its ack, so they are not latched here.
    assign w_sel_we    = (r_gnt == GNT_DMA) ? dma_we    : core_we;
    assign w_sel_addr  = (r_gnt == GNT_DMA) ? dma_addr  : core_addr;
    assign w_sel_wdata = (r_gnt == GNT_DMA) ? dma_wdata : core_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_gnt        <= GNT_CORE;
            r_last_grant <= GNT_DMA;   // core wins the first tie
            r_cnt        <= '0;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_winner;
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    r_cnt   <= c_LAT;
                    r_state <= w_sel_we ? c_ST_DONE : c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // Count of 1 marks the cycle MEM_LAT after the strobe,
                    // i.e. the one cycle mem_rdata is valid.
                    if (r_cnt == c_CNT_ONE) begin
                        if (r_gnt == GNT_DMA) begin
                            r_dma_rdata <= mem_rdata;
                        end else begin
                            r_core_rdata <= mem_rdata;
                        end
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_last_grant <= r_gnt;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register directly so that an asynchronous
    // reset silences the memory strobe and acks without waiting for a clock.
    assign w_access = (r_state == c_ST_ACCESS);
    assign w_done   = (r_state == c_ST_DONE);

    assign mem_en    = w_access;
    assign mem_we    = w_access & w_sel_we;
    assign mem_addr  = w_access ? w_sel_addr  : '0;
    assign mem_wdata = w_access ? w_sel_wdata : '0;

    assign core_ack  = w_done & (r_gnt == GNT_CORE);
    assign dma_ack   = w_done & (r_gnt == GNT_DMA);

    assign core_rdata = r_core_rdata;
    assign dma_rdata  = r_dma_rdata;

    assign busy = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Sequences and shares the single-port unified memory of the multicycle RISC-V core between two requesters: the core (fetch/LW/SW via the control plane) and a DMA/debug port.
- Provides a req/ack handshake per requester, fixed-latency memory sequencing, and round-robin or fixed-priority arbitration.
- Sits between the core datapath/control (memrw, address, write data) and the memory macro.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- FAIR, 1, 1 = round-robin between requesters; 0 = core always wins ties.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- core_req  in  1  core request; held until core_ack.
- core_we  in  1  1 = write, 0 = read; stable while core_req=1.
- core_addr  in  ADDR_W  address; stable while core_req=1.
- core_wdata  in  DATA_W  write data; stable while core_req=1.
- core_rdata  out  DATA_W  registered read data; valid in the core_ack cycle and held until the next read capture.
- core_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as the core_* set, for the DMA requester.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable (qualified by mem_en).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE; all outputs 0; both rdata registers 0.
  - last_grant=DMA, so the core wins the first tie.
  - Reset mid-transaction aborts it with no ack and drops mem_en in the same cycle.
- States:
  - IDLE: if any req, pick a winner, latch gnt, go to ACCESS; else stay.
  - ACCESS: mem_en=1 and mem_we=latched requester's we, for exactly 1 cycle. mem_addr and mem_wdata are muxed from the granted requester. Next state is DONE for writes, WAIT for reads; counter loaded with MEM_LAT.
  - WAIT: counter decrements each cycle. On the cycle the counter equals 1, capture mem_rdata into the granted requester's rdata register at the clock edge, then go to DONE.
  - DONE: granted requester's ack=1 for 1 cycle; update last_grant=gnt; go to IDLE. Requests are not sampled in DONE.
- Latency, from the first IDLE cycle with req seen to the ack cycle: read = 2+MEM_LAT cycles; write = 2 cycles.
- Arbitration:
  - Only one requester active: it wins.
  - Both active, FAIR=1: the requester not equal to last_grant wins.
  - Both active, FAIR=0: core wins.
  - The decision is made only in IDLE; no preemption once in ACCESS.
- Handshake:
  - Requester deasserts req at the edge ending its ack cycle, or keeps it high for a back-to-back transaction.
  - The DONE→IDLE gap guarantees a dropped req is seen low in IDLE.
- Output qualification:
  - mem_addr, mem_wdata and mem_we are 0 outside ACCESS.
  - The non-granted requester's rdata is untouched.
  - A write never modifies either rdata register.
- Protocol violation: if req drops before ack, the transaction still completes and ack still pulses. Changing addr/we while waiting is undefined; no check is required.
- Back-to-back: with both req held high and FAIR=1, grants alternate C,D,C,D…; the minimum issue interval is 3 cycles (writes).

Decomposition:
- Package rv_mem_pkg:
  - enum arb_state_t {IDLE, ACCESS, WAIT, DONE};
  - enum gnt_t {GNT_CORE=0, GNT_DMA=1};
  - MEM_LAT width constant.
- One sub-module, rv_arb_rr2: combinational 2-way picker. Inputs req[1:0], last_grant, fair. Output winner.
- The FSM, counter, rdata registers and muxes stay in rv_mem_arb.

Test Plan:
- Reset: rst_n=0 asserted mid-WAIT → mem_en, busy and acks 0 in the same cycle; after release, IDLE, rdata=0.
- Core read, MEM_LAT=2: memory returns 0xDEADBEEF from addr 0x40 → mem_en in cycle 1, core_ack in cycle 4 with core_rdata=0xDEADBEEF; dma_ack never asserts.
- DMA write: addr 0x80, data 0x12345678 → one mem_en+mem_we cycle with those values; dma_ack 2 cycles after the req is first seen; no rdata change.
- Simultaneous requests, FAIR=1, both held for 4 transactions → grant order CORE, DMA, CORE, DMA.
- Simultaneous requests, FAIR=0, both held → core is served every transaction; DMA waits until core_req drops, then is served.
- Early req drop: core_req deasserted in WAIT → core_ack still pulses once; the next IDLE cycle is idle; busy returns to 0.
